// File: rtl/affine_seq_pkg.sv
// Shared types for the affine transform sequencer.
//   state_t    : sequencer state encoding
//   ALU_FUNC_W : width of the ALU function select
package affine_seq_pkg;

    localparam int unsigned ALU_FUNC_W = 3;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        MUL11 = 4'd1,
        MUL12 = 4'd2,
        ADD1  = 4'd3,
        BIAS1 = 4'd4,
        MUL21 = 4'd5,
        MUL22 = 4'd6,
        ADD2  = 4'd7,
        BIAS2 = 4'd8,
        DONE  = 4'd9
    } state_t;

endpackage

// File: rtl/alu.sv
// picoMIPS combinational ALU.
// Ports:
//   a, b : n-bit operands
//   func : operation select (alucodes.sv)
//   y    : n-bit result
// MUL treats a and b as signed Q1.(n-1) / integer values: the 2n-bit
// product is arithmetically shifted right by n-1 (floor) and wraps to n bits.
`include "alucodes.sv"

module alu #(
    parameter int n = 8
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic [2:0]   func,
    output logic [n-1:0] y
);

    logic signed [2*n-1:0] prod;

    // Sign-extend both operands to full product width before multiplying.
    assign prod = $signed({{n{a[n-1]}}, a}) * $signed({{n{b[n-1]}}, b});

    // Result select.
    always_comb begin
        y = '0;
        case (func)
            `RI:     y = b;
            `RA:     y = a;
            `ADD:    y = a + b;
            `SUB:    y = a - b;
            `MUL:    y = n'(prod >>> (n - 1));
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alucodes.sv
// Shared ALU opcode definitions for the picoMIPS datapath.
// Included by every block that drives or decodes ALUFunc.
`ifndef ALUCODES_SV
`define ALUCODES_SV

`define RI  3'b000
`define ADD 3'b001
`define MUL 3'b010
`define RA  3'b011
`define SUB 3'b100

`endif

// File: rtl/affine_sequencer.sv
// Multi-cycle affine transform on one shared ALU:
//   x2 = A11*x1 + A12*y1 + B1
//   y2 = A21*x1 + A22*y1 + B2
// One ALU operation per cycle, eight compute cycles per transform.
// Ports:
//   clk, n_reset        : clock, synchronous active-low reset
//   in_valid/in_ready   : input handshake for x1, y1
//   x1, y1              : signed input coordinates
//   out_valid/out_ready : output handshake for x2, y2
//   x2, y2              : signed registered results
//   busy                : sequencer is not idle
`include "alucodes.sv"

module affine_sequencer
    import affine_seq_pkg::*;
#(
    parameter int unsigned       N   = 8,
    parameter logic signed [N-1:0] A11 = '0,
    parameter logic signed [N-1:0] A12 = '0,
    parameter logic signed [N-1:0] A21 = '0,
    parameter logic signed [N-1:0] A22 = '0,
    parameter logic signed [N-1:0] B1  = '0,
    parameter logic signed [N-1:0] B2  = '0
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x1,
    input  logic [N-1:0] y1,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] x2,
    output logic [N-1:0] y2,
    output logic         busy
);

    state_t                  state;
    state_t                  state_nxt;
    logic [N-1:0]            xl;
    logic [N-1:0]            yl;
    logic [N-1:0]            t;
    logic [N-1:0]            p;
    logic [ALU_FUNC_W-1:0]   alu_func;
    logic [N-1:0]            alu_a;
    logic [N-1:0]            alu_b;
    logic [N-1:0]            alu_y;
    logic                    accept;

    assign in_ready  = n_reset && (state == IDLE);
    assign busy      = n_reset && (state != IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and ALU operand selection.
    always_comb begin
        state_nxt = state;
        alu_func  = `RI;
        alu_a     = '0;
        alu_b     = '0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = MUL11;
            end
            MUL11: begin
                alu_func  = `MUL;
                alu_a     = xl;
                alu_b     = A11;
                state_nxt = MUL12;
            end
            MUL12: begin
                alu_func  = `MUL;
                alu_a     = yl;
                alu_b     = A12;
                state_nxt = ADD1;
            end
            ADD1: begin
                alu_func  = `ADD;
                alu_a     = t;
                alu_b     = p;
                state_nxt = BIAS1;
            end
            BIAS1: begin
                alu_func  = `ADD;
                alu_a     = t;
                alu_b     = B1;
                state_nxt = MUL21;
            end
            MUL21: begin
                alu_func  = `MUL;
                alu_a     = xl;
                alu_b     = A21;
                state_nxt = MUL22;
            end
            MUL22: begin
                alu_func  = `MUL;
                alu_a     = yl;
                alu_b     = A22;
                state_nxt = ADD2;
            end
            ADD2: begin
                alu_func  = `ADD;
                alu_a     = t;
                alu_b     = p;
                state_nxt = BIAS2;
            end
            BIAS2: begin
                alu_func  = `ADD;
                alu_a     = t;
                alu_b     = B2;
                state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    alu #(
        .n(N)
    ) u_alu (
        .a   (alu_a),
        .b   (alu_b),
        .func(alu_func),
        .y   (alu_y)
    );

    // Input latch and result registers; each compute state writes one target.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            xl <= '0;
            yl <= '0;
            t  <= '0;
            p  <= '0;
            x2 <= '0;
            y2 <= '0;
        end else begin
            if (accept) begin
                xl <= x1;
                yl <= y1;
            end
            case (state)
                MUL11, ADD1, MUL21, ADD2: t  <= alu_y;
                MUL12, MUL22:             p  <= alu_y;
                BIAS1:                    x2 <= alu_y;
                BIAS2:                    y2 <= alu_y;
                default: ;
            endcase
        end
    end

endmodule
